// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Brief    : E-stage multi-cycle multiply/divide unit owning the HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOp,
   input  logic        Start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);

   localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

   localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
   localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   localparam logic [3:0] c_OP_MULT  = 4'd1;
   localparam logic [3:0] c_OP_MULTU = 4'd2;
   localparam logic [3:0] c_OP_DIV   = 4'd3;
   localparam logic [3:0] c_OP_DIVU  = 4'd4;
   localparam logic [3:0] c_OP_MFHI  = 4'd5;
   localparam logic [3:0] c_OP_MFLO  = 4'd6;
   localparam logic [3:0] c_OP_MTHI  = 4'd7;
   localparam logic [3:0] c_OP_MTLO  = 4'd8;

   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_BUSY = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [3:0]         r_op;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;

   logic               w_arith_start;
   logic               w_op_is_mul;
   logic               w_launch;
   logic               w_last;
   logic               w_commit;
   logic               w_mthi;
   logic               w_mtlo;
   logic               w_div_zero;

   logic [63:0]        w_prod_s;
   logic [63:0]        w_prod_u;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [31:0]        w_a_mag;
   logic [31:0]        w_b_mag;
   logic [31:0]        w_sq_mag;
   logic [31:0]        w_sr_mag;
   logic [31:0]        w_sq;
   logic [31:0]        w_sr;
   logic [31:0]        w_uq;
   logic [31:0]        w_ur;
   logic [31:0]        w_res_hi;
   logic [31:0]        w_res_lo;

   assign w_arith_start = Start && (MDUOp >= c_OP_MULT) && (MDUOp <= c_OP_DIVU);
   assign w_op_is_mul   = (MDUOp == c_OP_MULT) || (MDUOp == c_OP_MULTU);
   assign w_div_zero    = ((r_op == c_OP_DIV) || (r_op == c_OP_DIVU)) && (r_b == 32'd0);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: if (w_arith_start) w_state_nxt = c_ST_BUSY;
         c_ST_BUSY: if (w_last)        w_state_nxt = c_ST_IDLE;
         default:                      w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Control outputs; a zero divisor runs the full latency but never commits
   always_comb begin
      w_launch = 1'b0;
      w_last   = 1'b0;
      w_commit = 1'b0;
      w_mthi   = 1'b0;
      w_mtlo   = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            w_launch = w_arith_start;
            w_mthi   = !Start && (MDUOp == c_OP_MTHI);
            w_mtlo   = !Start && (MDUOp == c_OP_MTLO);
         end
         c_ST_BUSY: begin
            w_last   = (r_cnt == c_CNT_ONE);
            w_commit = w_last && !w_div_zero;
         end
         default: ;
      endcase
   end

   assign Busy = (r_state == c_ST_BUSY);

   // Counter, operand latch and architectural HI/LO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_op  <= 4'd0;
         r_a   <= 32'd0;
         r_b   <= 32'd0;
         r_hi  <= 32'd0;
         r_lo  <= 32'd0;
      end else begin
         if (w_launch) begin
            r_cnt <= w_op_is_mul ? c_MULT_LOAD : c_DIV_LOAD;
            r_op  <= MDUOp;
            r_a   <= A;
            r_b   <= B;
         end else if (r_state == c_ST_BUSY) begin
            r_cnt <= r_cnt - c_CNT_ONE;
         end

         if (w_commit) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else begin
            if (w_mthi) r_hi <= A;
            if (w_mtlo) r_lo <= A;
         end
      end
   end

   // Sign-extended operands give the signed product in the low 64 bits
   assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

   // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow corner
   assign w_a_neg  = r_a[31];
   assign w_b_neg  = r_b[31];
   assign w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
   assign w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
   assign w_sq_mag = w_a_mag / w_b_mag;
   assign w_sr_mag = w_a_mag % w_b_mag;
   assign w_sq     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
   assign w_sr     = w_a_neg ? (32'd0 - w_sr_mag) : w_sr_mag;

   assign w_uq     = r_a / r_b;
   assign w_ur     = r_a % r_b;

   always_comb begin
      w_res_hi = r_hi;
      w_res_lo = r_lo;
      case (r_op)
         c_OP_MULT: begin
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
         end
         c_OP_MULTU: begin
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
         end
         c_OP_DIV: begin
            w_res_hi = w_sr;
            w_res_lo = w_sq;
         end
         c_OP_DIVU: begin
            w_res_hi = w_ur;
            w_res_lo = w_uq;
         end
         default: ;
      endcase
   end

   assign HI = r_hi;
   assign LO = r_lo;

   always_comb begin
      MDUOut = 32'd0;
      if (MDUOp == c_OP_MFHI) MDUOut = r_hi;
      if (MDUOp == c_OP_MFLO) MDUOut = r_lo;
   end

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu
// Brief    : Directed self-checking bench for e_mdu with a cycle-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  MDUOp = 4'd0;
   logic        Start = 1'b0;
   logic [31:0] A     = 32'd0;
   logic [31:0] B     = 32'd0;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOut;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk    (clk),
      .reset  (reset),
      .MDUOp  (MDUOp),
      .Start  (Start),
      .A      (A),
      .B      (B),
      .Busy   (Busy),
      .HI     (HI),
      .LO     (LO),
      .MDUOut (MDUOut)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: {commit_ok, hi, lo} straight from the arithmetic definitions
   function automatic logic [64:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p;
      logic [31:0] hi, lo;
      bit          ok;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ok = 1'b1;
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         4'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
         4'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
         4'd3: if (b == 32'd0) ok = 1'b0;
               else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
         4'd4: if (b == 32'd0) ok = 1'b0;
               else begin lo = a / b; hi = a % b; end
         default: ok = 1'b0;
      endcase
      return {ok, hi, lo};
   endfunction

   // Pending-result model: an operation launched on edge c lands on edge c+N
   logic [31:0] m_hi, m_lo;
   logic [64:0] m_res;
   bit          m_pend;
   int          m_cyc, m_due;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
         m_res  <= 65'd0;
         m_pend <= 1'b0;
         m_cyc  <= 0;
         m_due  <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_pend) begin
            if (m_cyc == m_due) begin
               m_pend <= 1'b0;
               if (m_res[64]) begin
                  m_hi <= m_res[63:32];
                  m_lo <= m_res[31:0];
               end
            end
         end else if (Start && MDUOp >= 4'd1 && MDUOp <= 4'd4) begin
            m_pend <= 1'b1;
            m_due  <= m_cyc + ((MDUOp <= 4'd2) ? MC : DC);
            m_res  <= model_op(MDUOp, A, B);
         end else if (!Start && MDUOp == 4'd7) begin
            m_hi <= A;
         end else if (!Start && MDUOp == 4'd8) begin
            m_lo <= A;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check32("busy", {31'd0, Busy}, {31'd0, m_pend});
         check32("hi", HI, m_hi);
         check32("lo", LO, m_lo);
         check32("mduout", MDUOut,
                 (MDUOp == 4'd5) ? m_hi : ((MDUOp == 4'd6) ? m_lo : 32'd0));
      end
   end

   task automatic expect_hl(input string name, input logic [31:0] hi, input logic [31:0] lo);
      check32({name, " hi"}, HI, hi);
      check32({name, " lo"}, LO, lo);
      check32({name, " model hi"}, m_hi, hi);
      check32({name, " model lo"}, m_lo, lo);
   endtask

   // Counts Busy-high negedges until Busy drops; leaves time at negedge+1
   task automatic wait_busy(input string name, input int n);
      int cnt  = 0;
      bit done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (Busy) cnt++;
         else      done = 1'b1;
      end
      #1;
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL %s timeout: Busy still high after 64 cycles", name);
      end
      check_int({name, " busy cycles"}, cnt, n);
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] hi,
                         input logic [31:0] lo);
      MDUOp = op;
      Start = 1'b1;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      Start = 1'b0;
      MDUOp = 4'd0;
      A     = $urandom;
      B     = $urandom;
      wait_busy(name, n);
      expect_hl(name, hi, lo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b0;
      #1 chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check32("reset busy", {31'd0, Busy}, 32'd0);
      expect_hl("reset", 32'd0, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      run_op("mult -2*3",   4'd1, 32'hFFFF_FFFE, 32'd3,        MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu max",   4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div -7/2",    4'd3, 32'hFFFF_FFF9, 32'd2,        DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu 7/2",    4'd4, 32'd7,         32'd2,        DC, 32'd1,         32'd3);

      MDUOp = 4'd7; A = 32'h1234_5678;
      @(posedge clk); #1;
      check32("mthi", HI, 32'h1234_5678);
      MDUOp = 4'd8; A = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      check32("mtlo", LO, 32'h9ABC_DEF0);
      MDUOp = 4'd5; #1;
      check32("mfhi out", MDUOut, 32'h1234_5678);
      MDUOp = 4'd6; #1;
      check32("mflo out", MDUOut, 32'h9ABC_DEF0);
      MDUOp = 4'd0;
      @(posedge clk); #1;

      run_op("div by zero", 4'd3, 32'd55,        32'd0,        DC, 32'h1234_5678, 32'h9ABC_DEF0);
      run_op("div min/-1",  4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0,        32'h8000_0000);

      // Start and mthi during BUSY must both be ignored
      MDUOp = 4'd1; Start = 1'b1; A = 32'd7; B = 32'd6;
      @(posedge clk); #1;
      Start = 1'b0; MDUOp = 4'd0;
      @(posedge clk); #1;
      MDUOp = 4'd3; Start = 1'b1; A = 32'd100; B = 32'd5;
      @(posedge clk); #1;
      MDUOp = 4'd7; Start = 1'b0; A = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      MDUOp = 4'd0;
      wait_busy("mult ignore tail", MC - 3);
      expect_hl("mult ignore", 32'd0, 32'd42);

      // Asynchronous reset in the middle of a divide
      MDUOp = 4'd3; Start = 1'b1; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      Start = 1'b0; MDUOp = 4'd0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check32("async reset busy", {31'd0, Busy}, 32'd0);
      check32("async reset hi", HI, 32'd0);
      check32("async reset lo", LO, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check32("no late commit busy", {31'd0, Busy}, 32'd0);
      expect_hl("no late commit", 32'd0, 32'd0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
